// File: rtl/kbd_fifo_if.sv
// Key-event FIFO bus: the producer/consumer side of kbd_fifo.
// The master drives key events, read strobes and overflow clears.
// The slave (the FIFO) returns the head entry and status.
interface kbd_fifo_if #(
  parameter int AW = 3
);
  logic        in_valid;
  logic [15:0] in_data;
  logic        ren;
  logic        ovf_clr;
  logic [15:0] rdata;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        overflow;

  modport master (
    output in_valid, in_data, ren, ovf_clr,
    input  rdata, count, empty, full, overflow
  );

  modport slave (
    input  in_valid, in_data, ren, ovf_clr,
    output rdata, count, empty, full, overflow
  );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard event FIFO with first-word fall-through read.
// Optionally drops typematic auto-repeat make events.
// It keeps a sticky overflow flag for events lost while the FIFO is full.
module kbd_fifo #(
  parameter int DEPTH         = 8,
  parameter int AW            = 3,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input logic      clk,
  input logic      rst,
  kbd_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [15:0]   storage [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    last_make_q, last_make_d;

  logic          is_empty;
  logic          is_full;
  logic          valid_evt;
  logic          is_break;
  logic [7:0]    ascii;
  logic          filtered;
  logic          accept;
  logic          pop;
  logic          push;

  // Status comes from registered count only.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign ascii    = bus.in_data[7:0];
  assign is_break = bus.in_data[8];

  // Accept, filter and push/pop decisions, plus the next-state values.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    last_make_d = last_make_q;

    // Events whose ASCII byte is zero carry no key and are ignored outright.
    valid_evt = bus.in_valid && (ascii != 8'h00);
    filtered  = FILTER_REPEAT && valid_evt && !is_break && (ascii == last_make_q);
    accept    = valid_evt && !filtered;
    // A pop needs stored data, so an empty FIFO never bypasses in to out.
    pop       = bus.ren && !is_empty;
    // When full, a same-cycle pop frees the slot that the push takes.
    push      = accept && (!is_full || pop);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // A fresh overflow beats a same-cycle clear.
    if (accept && is_full && !pop) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end

    // Repeat tracking follows every valid event, even when it gets dropped.
    if (FILTER_REPEAT && valid_evt) begin
      if (!is_break) begin
        last_make_d = ascii;
      end else if (ascii == last_make_q) begin
        last_make_d = 8'h00;
      end
    end
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      storage[wr_ptr_q] <= bus.in_data;
    end
  end

  // State registers; reset overrides all same-cycle activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_make_q <= 8'h00;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_make_q <= last_make_d;
    end
  end

  assign bus.rdata    = is_empty ? 16'h0000 : storage[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_kbd_fifo.sv
// Bench for kbd_fifo: directed scenarios plus random traffic.
// Results are compared against a queue-based reference model.
module tb_kbd_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;

  kbd_fifo_if #(.AW(AW)) bus ();

  kbd_fifo #(.DEPTH(DEPTH), .AW(AW), .FILTER_REPEAT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model state.
  logic [15:0] mq [$];
  logic [7:0]  m_last;
  logic        m_ovf;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: what one clock edge does to the FIFO contents.
  task automatic model_step(input logic v, input logic [15:0] d, input logic r,
                            input logic oc, input logic rs);
    logic ev, filt, acc, do_pop, was_full, set_ovf;
    if (rs) begin
      mq.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      return;
    end
    ev       = v && (d[7:0] != 8'h00);
    filt     = ev && !d[8] && (d[7:0] == m_last);
    acc      = ev && !filt;
    do_pop   = r && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    set_ovf  = 1'b0;
    if (ev) begin
      if (!d[8]) m_last = d[7:0];
      else if (d[7:0] == m_last) m_last = 8'h00;
    end
    if (do_pop) void'(mq.pop_front());
    if (acc) begin
      if (!was_full || do_pop) mq.push_back(d);
      else set_ovf = 1'b1;
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    logic [15:0] exp_rd;
    exp_rd = (mq.size() > 0) ? mq[0] : 16'h0000;
    check_val({tag, ".rdata"},    32'(bus.rdata),    32'(exp_rd));
    check_val({tag, ".count"},    32'(bus.count),    32'(mq.size()));
    check_val({tag, ".empty"},    32'(bus.empty),    32'(mq.size() == 0));
    check_val({tag, ".full"},     32'(bus.full),     32'(mq.size() == DEPTH));
    check_val({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  // One clock: apply inputs, let the edge happen, update model, compare.
  task automatic cycle(input string tag, input logic v, input logic [15:0] d,
                       input logic r, input logic oc, input logic rs);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.ren      = r;
    bus.ovf_clr  = oc;
    rst          = rs;
    @(posedge clk);
    model_step(v, d, r, oc, rs);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    m_last = 8'h00;
    m_ovf  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    bus.ren      = 1'b0;
    bus.ovf_clr  = 1'b0;
    rst          = 1'b1;

    // Reset state.
    cycle("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check_val("reset.rdata_const", 32'(bus.rdata), 32'h0);
    check_val("reset.empty_const", 32'(bus.empty), 32'h1);

    // Make then break of 'a', then two reads.
    cycle("t31.push1", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    check_val("t31.rd1", 32'(bus.rdata), 32'h0061);
    check_val("t31.cnt1", 32'(bus.count), 32'd1);
    cycle("t31.push2", 1'b1, 16'h0161, 1'b0, 1'b0, 1'b0);
    check_val("t31.cnt2", 32'(bus.count), 32'd2);
    cycle("t31.pop1", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t31.rd2", 32'(bus.rdata), 32'h0161);
    cycle("t31.pop2", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_val("t31.rd3", 32'(bus.rdata), 32'h0000);
    check_val("t31.empty", 32'(bus.empty), 32'h1);
    cycle("t31.pop_empty", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Nine distinct makes into an 8-deep FIFO.
    for (int i = 0; i < 9; i++)
      cycle("t32.fill", 1'b1, 16'h0061 + 16'(i), 1'b0, 1'b0, 1'b0);
    check_val("t32.full", 32'(bus.full), 32'h1);
    check_val("t32.ovf", 32'(bus.overflow), 32'h1);
    check_val("t32.head", 32'(bus.rdata), 32'h0061);

    // Push and pop together while full.
    cycle("t33.pushpop", 1'b1, 16'h0062, 1'b1, 1'b0, 1'b0);
    check_val("t33.count", 32'(bus.count), 32'd8);
    check_val("t33.head", 32'(bus.rdata), 32'h0062);

    // Clear overflow while a new overflow event arrives: overflow stays set.
    cycle("t36.ovf_race", 1'b1, 16'h007a, 1'b0, 1'b1, 1'b0);
    check_val("t36.ovf_kept", 32'(bus.overflow), 32'h1);
    cycle("t36.ovf_clr", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Drain, checking order along the way.
    for (int i = 0; i < 8; i++)
      cycle("t32.drain", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Repeat filter.
    cycle("t34.a", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    cycle("t34.a_rep", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    cycle("t34.a_rep", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    cycle("t34.a_brk", 1'b1, 16'h0161, 1'b0, 1'b0, 1'b0);
    cycle("t34.a2", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
    check_val("t34.count", 32'(bus.count), 32'd3);

    // Reset mid-stream with overflow set.
    for (int i = 0; i < 6; i++)
      cycle("t36.fill", 1'b1, 16'h0041 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle("t36.rst", 1'b1, 16'h0050, 1'b1, 1'b0, 1'b1);
    check_val("t36.count", 32'(bus.count), 32'd0);
    check_val("t36.ovf", 32'(bus.overflow), 32'h0);

    // Empty FIFO: read and write together, then an all-zero event.
    cycle("t35.rw_empty", 1'b1, 16'h0041, 1'b1, 1'b0, 1'b0);
    check_val("t35.rd", 32'(bus.rdata), 32'h0041);
    cycle("t35.zero", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_val("t35.count", 32'(bus.count), 32'd1);
    idle("t35.idle");

    // Random traffic over a small key alphabet so repeats and fills both occur.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  a;
      logic [15:0] d;
      logic        v, r, oc, rs;
      case ($urandom_range(0, 4))
        0: a = 8'h00;
        1: a = 8'h61;
        2: a = 8'h62;
        3: a = 8'h63;
        default: a = 8'($urandom_range(1, 255));
      endcase
      d  = {7'b0, 1'($urandom_range(0, 1)), a};
      v  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 35);
      oc = ($urandom_range(0, 99) < 5);
      rs = ($urandom_range(0, 999) < 8);
      cycle("rand", v, d, r, oc, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
